// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one input stream with a destination
// select, NUMBER output streams and the out-of-range select pulse.
interface stream_demux_if #(
    parameter int WIDTH  = 1,
    parameter int NUMBER = 2
);
    localparam int SelectW = $clog2(NUMBER);

    logic [SelectW-1:0] sel;
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data [NUMBER];
    logic               out_valid [NUMBER];
    logic               out_ready [NUMBER];
    logic               sel_err;

    modport master (
        output sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/stream_demux.sv
// One-entry stream demultiplexer: routes each beat to out[sel] with a single
// holding register. Define STREAM_DEMUX_STATS_EN to add per-output xfer_cnt.
module stream_demux #(
    parameter int WIDTH  = 1,
    parameter int NUMBER = 2
) (
    input  logic          clk,
    input  logic          rst,
    stream_demux_if.slave bus
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [15:0]   xfer_cnt [NUMBER]
`endif
);
    localparam int SelectW = $clog2(NUMBER);
    localparam logic [SelectW:0] NumLimit = (SelectW + 1)'(NUMBER);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state;
    logic [SelectW-1:0] dest;
    logic [WIDTH-1:0]   data;
    logic               sel_err_q;

    logic full;
    logic drain;
    logic in_ready;
    logic accept;
    logic in_range;

    // The held beat may leave and a new one enter in the same cycle.
    assign full     = (state == FULL);
    assign drain    = full && bus.out_ready[dest];
    assign in_ready = !full || bus.out_ready[dest];
    assign accept   = bus.in_valid && in_ready;
    assign in_range = ({1'b0, bus.sel} < NumLimit);

    assign bus.in_ready = in_ready;
    assign bus.sel_err  = sel_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            dest      <= '0;
            data      <= '0;
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= accept && !in_range;
            // Out-of-range beats are dropped; only the drain rule moves state.
            if (accept && in_range) begin
                state <= FULL;
                dest  <= bus.sel;
                data  <= bus.in_data;
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end

    for (genvar i = 0; i < NUMBER; i++) begin : g_out
        assign bus.out_valid[i] = full && (dest == SelectW'(i));
        assign bus.out_data[i]  = data;
    end

`ifdef STREAM_DEMUX_STATS_EN
    for (genvar i = 0; i < NUMBER; i++) begin : g_stats
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                xfer_cnt[i] <= '0;
            end else if (bus.out_valid[i] && bus.out_ready[i]) begin
                xfer_cnt[i] <= xfer_cnt[i] + 16'd1;
            end
        end
    end
`endif
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width of the input and each output.
REQ-002 SHALL have parameter NUMBER, default 2, count of output streams; NUMBER >= 2.
REQ-003 SHALL have localparam SelectW = $clog2(NUMBER), the select width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port sel  input  SelectW  destination index for the current input beat.
REQ-007 SHALL have port in_data  input  WIDTH  input beat payload.
REQ-008 SHALL have port in_valid  input  1  input beat present.
REQ-009 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-010 SHALL have port out_data  output  WIDTH x [NUMBER]  per-output payload, unpacked array.
REQ-011 SHALL have port out_valid  output  [NUMBER]  per-output beat present.
REQ-012 SHALL have port out_ready  input  [NUMBER]  per-output consumer ready.
REQ-013 SHALL have port sel_err  output  1  one-cycle pulse: a beat with sel >= NUMBER was dropped.

Function
REQ-014 SHALL accept an input beat on a rising edge where in_valid && in_ready; sel and in_data are sampled with it.
REQ-015 SHALL hold one registered beat (data, destination index dest) plus a full flag; two states EMPTY (full=0) and FULL (full=1).
REQ-016 SHALL drive out_valid[i] = full && (dest == i); all other out_valid bits 0.
REQ-017 SHALL drive all out_data[i] from the single data register; out_data content is don't-care where out_valid[i]=0.
REQ-018 SHALL drive in_ready = !full || out_ready[dest] (combinational same-cycle drain-and-refill).
REQ-019 SHALL, in EMPTY, on accept of an in-range beat, go FULL next cycle; latency in_valid to out_valid is exactly 1 cycle.
REQ-020 SHALL, in FULL, on out_ready[dest] with no accept, go EMPTY.
REQ-021 SHALL, in FULL, on out_ready[dest] with accept of an in-range beat, stay FULL with the new beat and dest; no bubble.
REQ-022 SHALL, in FULL without out_ready[dest], hold data and dest stable and keep in_ready=0.
REQ-023 SHALL treat an accepted beat with sel >= NUMBER as dropped: no register load, sel_err=1 for the following cycle, and the state is set only by the drain rules.
REQ-024 SHALL ignore out_ready[i] for i != dest; an out_ready assertion never alters state while EMPTY.
REQ-025 SHALL deliver beats in acceptance order; no beat is lost or duplicated except per REQ-023.

Reset
REQ-026 SHALL, while rst=1, asynchronously force full=0, dest=0, data=0 and sel_err=0; hence out_valid all 0, out_data all 0 and in_ready=1.
REQ-027 SHALL discard a held beat when rst is asserted mid-transfer; it is never presented after reset.
REQ-028 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro STREAM_DEMUX_STATS_EN defined, add output port xfer_cnt  output  16 x [NUMBER]: per-output count of completed handshakes (out_valid[i] && out_ready[i]).
REQ-030 SHALL make each xfer_cnt entry reset to 0 and wrap modulo 2^16 (0xFFFF+1 -> 0x0000).
REQ-031 SHALL, without STREAM_DEMUX_STATS_EN, omit the xfer_cnt port and its counters entirely; all other behaviour is identical.

Verification (WIDTH=8, NUMBER=3)
REQ-032 SHALL cover: reset, then in_data=0xA5, sel=2, in_valid=1 for one cycle -> next cycle out_valid=3'b100, out_data[2]=0xA5; out_ready[2]=1 -> EMPTY the cycle after.
REQ-033 SHALL cover: FULL with dest=1 and out_ready[1]=0 for 5 cycles -> in_ready=0, out_data[1] stable; out_ready[0]=1 and out_ready[2]=1 have no effect.
REQ-034 SHALL cover: back-to-back beats 0x01,0x02,0x03 to sel 0,1,2 with all out_ready=1 -> in_ready stays 1; outputs see one beat each on consecutive cycles, no bubble.
REQ-035 SHALL cover: sel=3, in_data=0x77 accepted -> sel_err=1 for exactly one cycle, no out_valid asserted, next sel=0 beat delivered normally.
REQ-036 SHALL cover: rst asserted while FULL, dest=2, data=0x5A -> out_valid=0 immediately, and 0x5A never appears after reset release.
REQ-037 SHALL cover, with STREAM_DEMUX_STATS_EN: 65537 completed transfers on output 0 -> xfer_cnt[0]=1, xfer_cnt[1]=xfer_cnt[2]=0.
